// File: rtl/hamming_pkg.sv
// ============================================================================
//  Module      : hamming_pkg
//  Description : Shared types, codeword bit positions and the SECDED syndrome
//                helper for the UART Hamming decoder.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package hamming_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DECODE  = 3'd1,
        ST_SEND    = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4
    } state_t;

    // Hamming positions (1-based); codeword bit index is position - 1
    localparam int c_pos_p1 = 1;
    localparam int c_pos_p2 = 2;
    localparam int c_pos_p4 = 4;
    localparam int c_pos_d0 = 3;
    localparam int c_pos_d1 = 5;
    localparam int c_pos_d2 = 6;
    localparam int c_pos_d3 = 7;

    // Returns {syndrome[2:0], overall_parity}
    function automatic logic [3:0] hamming_syndrome(input logic [7:0] code);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (code[i]) s = s ^ 3'(i + 1);
        end
        return {s, ^code};
    endfunction

endpackage

`default_nettype wire

// File: rtl/hamming_uart_decoder_if.sv
// ============================================================================
//  Module      : hamming_uart_decoder_if
//  Description : Receiver/transmitter-side signal bundle of the decoder.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface hamming_uart_decoder_if #(
    parameter int FIFO_DEPTH = 4
);
    logic [7:0]                    rx_data;
    logic                          rx_data_ready;
    logic                          tx_busy;
    logic [7:0]                    tx_data;
    logic                          tx_start;
    logic                          err_single;
    logic                          err_double;
    logic [2:0]                    err_loc;
    logic                          overflow;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;

    modport master (
        output rx_data, rx_data_ready, tx_busy,
        input  tx_data, tx_start, err_single, err_double, err_loc, overflow, fifo_level
    );

    modport slave (
        input  rx_data, rx_data_ready, tx_busy,
        output tx_data, tx_start, err_single, err_double, err_loc, overflow, fifo_level
    );
endinterface

`default_nettype wire

// File: rtl/hamming_uart_decoder_sync_fifo.sv
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO, power-of-two depth.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     wr_en,
    input  wire logic [WIDTH-1:0]         wr_data,
    input  wire logic                     rd_en,
    output logic      [WIDTH-1:0]         rd_data,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   level
);
    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_level;
    logic             w_push;
    logic             w_pop;

    // Fullness uses the pre-pop level, so a write while full is always refused
    assign full    = (r_level == (c_aw+1)'(DEPTH));
    assign empty   = (r_level == '0);
    assign w_push  = wr_en && !full;
    assign w_pop   = rd_en && !empty;
    assign rd_data = r_mem[r_rd_ptr];
    assign level   = r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (c_aw+1)'(1);
                2'b01:   r_level <= r_level - (c_aw+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

`default_nettype wire

// File: rtl/hamming_uart_decoder.sv
// ============================================================================
//  Module      : hamming_uart_decoder
//  Description : Buffers received SECDED (7,4)+parity codewords, corrects or
//                flags them and hands the nibble to the UART transmitter.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module hamming_uart_decoder
    import hamming_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter bit         ASCII_HEX  = 1'b1,
    parameter logic [7:0] ERR_BYTE   = 8'hFF
) (
    input wire logic               clk,
    input wire logic               rst_n,
    hamming_uart_decoder_if.slave  bus
);
    localparam int c_lw = $clog2(FIFO_DEPTH) + 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_pop;
    logic            w_tx_start;
    logic            w_full;
    logic            w_empty;
    logic [7:0]      w_head;
    logic [c_lw-1:0] w_level;

    logic [7:0]      r_code;
    logic [7:0]      r_tx_data;
    logic            r_err_single;
    logic            r_err_double;
    logic [2:0]      r_err_loc;
    logic            r_overflow;

    logic [3:0]      w_synd;
    logic [2:0]      w_s;
    logic            w_p;
    logic            w_uncorr;
    logic [7:0]      w_fixed;
    logic [3:0]      w_nibble;
    logic [7:0]      w_byte;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.rx_data_ready),
        .wr_data (bus.rx_data),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .level   (w_level)
    );

    always_comb begin
        w_synd   = hamming_syndrome(r_code);
        w_s      = w_synd[3:1];
        w_p      = w_synd[0];
        w_uncorr = (w_s != 3'd0) && !w_p;
        w_fixed  = r_code;
        if ((w_s != 3'd0) && w_p) w_fixed[w_s - 3'd1] = ~r_code[w_s - 3'd1];
        w_nibble = {w_fixed[c_pos_d3-1], w_fixed[c_pos_d2-1],
                    w_fixed[c_pos_d1-1], w_fixed[c_pos_d0-1]};
        if (w_uncorr)
            w_byte = ERR_BYTE;
        else if (ASCII_HEX)
            w_byte = (w_nibble < 4'd10) ? 8'h30 + {4'h0, w_nibble}
                                        : 8'h37 + {4'h0, w_nibble};
        else
            w_byte = {4'h0, w_nibble};
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tx_start  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE:  w_state_nxt = ST_SEND;
            ST_SEND: begin
                if (!bus.tx_busy) begin
                    w_tx_start  = 1'b1;
                    w_state_nxt = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: if (bus.tx_busy)  w_state_nxt = ST_WAIT_LO;
            ST_WAIT_LO: if (!bus.tx_busy) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_code       <= 8'h00;
            r_tx_data    <= 8'h00;
            r_err_single <= 1'b0;
            r_err_double <= 1'b0;
            r_err_loc    <= 3'd0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_err_single <= 1'b0;
            r_err_double <= 1'b0;
            if (w_pop) r_code <= w_head;
            if (r_state == ST_DECODE) begin
                r_tx_data <= w_byte;
                if (w_uncorr) begin
                    r_err_double <= 1'b1;
                end else if (w_p) begin
                    // s==0 with odd parity means only bit 7 flipped: location 0
                    r_err_single <= 1'b1;
                    r_err_loc    <= w_s;
                end
            end
            if (bus.rx_data_ready && w_full) r_overflow <= 1'b1;
        end
    end

    assign bus.tx_data    = r_tx_data;
    assign bus.tx_start   = w_tx_start;
    assign bus.err_single = r_err_single;
    assign bus.err_double = r_err_double;
    assign bus.err_loc    = r_err_loc;
    assign bus.overflow   = r_overflow;
    assign bus.fifo_level = w_level;

endmodule

`default_nettype wire

// File: tb/tb_hamming_uart_decoder.sv
// ============================================================================
//  Module      : tb_hamming_uart_decoder
//  Description : Scoreboard bench for the Hamming UART decoder with a simple
//                busy-driven transmitter model.
//  Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hamming_uart_decoder;
    localparam int FIFO_DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hamming_uart_decoder_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    hamming_uart_decoder #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ASCII_HEX  (1'b1),
        .ERR_BYTE   (8'hFF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic       es;
        logic       ed;
        logic [2:0] loc;
        logic       lat;
        int         issue;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   bad    = 0;
    int   cyc    = 0;
    int   pulses = 0;
    int   busy_cnt = 0;
    logic hold_busy  = 1'b0;
    logic start_seen = 1'b0;
    logic prev_start = 1'b0;
    logic seen_s     = 1'b0;
    logic seen_d     = 1'b0;

    assign bus.tx_busy = hold_busy || (busy_cnt != 0);

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmitter: busy rises just after the edge that consumed tx_start
    always @(posedge clk) begin
        #1;
        if (start_seen) begin
            busy_cnt   = 3;
            start_seen = 1'b0;
        end else if (busy_cnt != 0) begin
            busy_cnt--;
        end
    end

    // Monitor / scoreboard checker
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen_s     = 1'b0;
            seen_d     = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (bus.err_single) seen_s = 1'b1;
            if (bus.err_double) seen_d = 1'b1;
            if (bus.tx_start) begin
                pulses++;
                start_seen = 1'b1;
                check("start_back_to_back", 32'(prev_start), 32'd0);
                check("start_while_busy", 32'(bus.tx_busy), 32'd0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: got tx_data %0h expected no start", bus.tx_data);
                end else begin
                    e = sb.pop_front();
                    check("tx_data", 32'(bus.tx_data), 32'(e.data));
                    check("err_single", 32'(seen_s), 32'(e.es));
                    check("err_double", 32'(seen_d), 32'(e.ed));
                    check("err_loc", 32'(bus.err_loc), 32'(e.loc));
                    if (e.lat) check("latency", 32'(cyc - e.issue), 32'd3);
                end
                seen_s = 1'b0;
                seen_d = 1'b0;
            end
            prev_start = bus.tx_start;
        end
    end

    task automatic send(input logic [7:0] code, input logic expect_out, input logic [7:0] data,
                        input logic es, input logic ed, input logic [2:0] loc, input logic lat);
        @(negedge clk);
        bus.rx_data       = code;
        bus.rx_data_ready = 1'b1;
        if (expect_out) sb.push_back('{data: data, es: es, ed: ed, loc: loc, lat: lat, issue: cyc});
        @(negedge clk);
        bus.rx_data_ready = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_data"},    32'(bus.tx_data),    32'd0);
        check({tag, "_tx_start"},   32'(bus.tx_start),   32'd0);
        check({tag, "_err_single"}, 32'(bus.err_single), 32'd0);
        check({tag, "_err_double"}, 32'(bus.err_double), 32'd0);
        check({tag, "_err_loc"},    32'(bus.err_loc),    32'd0);
        check({tag, "_overflow"},   32'(bus.overflow),   32'd0);
        check({tag, "_fifo_level"}, 32'(bus.fifo_level), 32'd0);
    endtask

    initial begin
        int p0;
        bus.rx_data       = 8'h00;
        bus.rx_data_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed codewords, one at a time
        send(8'hD2, 1'b1, 8'h41, 1'b0, 1'b0, 3'd0, 1'b1);  wait_empty(200); repeat (8) @(negedge clk);
        send(8'h52, 1'b1, 8'h41, 1'b1, 1'b0, 3'd0, 1'b0);  wait_empty(200); repeat (8) @(negedge clk);
        send(8'hC2, 1'b1, 8'h41, 1'b1, 1'b0, 3'd5, 1'b0);  wait_empty(200); repeat (8) @(negedge clk);
        send(8'hC3, 1'b1, 8'hFF, 1'b0, 1'b1, 3'd5, 1'b0);  wait_empty(200); repeat (8) @(negedge clk);

        // Back-to-back burst through the FIFO
        send(8'h1E, 1'b1, 8'h33, 1'b0, 1'b0, 3'd5, 1'b0);
        send(8'h1F, 1'b1, 8'h33, 1'b1, 1'b0, 3'd1, 1'b0);
        send(8'hFF, 1'b1, 8'h46, 1'b0, 1'b0, 3'd1, 1'b0);
        send(8'h40, 1'b1, 8'h30, 1'b1, 1'b0, 3'd7, 1'b0);
        send(8'h03, 1'b1, 8'hFF, 1'b0, 1'b1, 3'd7, 1'b0);
        wait_empty(400); repeat (8) @(negedge clk);

        // Overflow: park the FSM in WAIT_LO with busy held high
        send(8'h00, 1'b1, 8'h30, 1'b0, 1'b0, 3'd7, 1'b0);
        wait_empty(200);
        @(negedge clk);
        hold_busy = 1'b1;
        repeat (3) @(negedge clk);
        p0 = pulses;
        send(8'hD2, 1'b1, 8'h41, 1'b0, 1'b0, 3'd7, 1'b0);
        send(8'h1E, 1'b1, 8'h33, 1'b0, 1'b0, 3'd7, 1'b0);
        send(8'hFF, 1'b1, 8'h46, 1'b0, 1'b0, 3'd7, 1'b0);
        check("overflow_before_full", 32'(bus.overflow), 32'd0);
        send(8'h00, 1'b1, 8'h30, 1'b0, 1'b0, 3'd7, 1'b0);
        send(8'h52, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        send(8'hC2, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        check("fifo_level_full", 32'(bus.fifo_level), 32'd4);
        check("overflow_set", 32'(bus.overflow), 32'd1);
        check("no_start_while_held", 32'(pulses - p0), 32'd0);
        hold_busy = 1'b0;
        wait_empty(400);
        repeat (10) @(negedge clk);
        check("overflow_pulse_count", 32'(pulses - p0), 32'd4);
        check("overflow_sticky", 32'(bus.overflow), 32'd1);
        check("fifo_level_drained", 32'(bus.fifo_level), 32'd0);

        // Reset while in WAIT_LO with two bytes queued
        send(8'hD2, 1'b1, 8'h41, 1'b0, 1'b0, 3'd7, 1'b0);
        wait_empty(200);
        @(negedge clk);
        hold_busy = 1'b1;
        repeat (3) @(negedge clk);
        send(8'h1E, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        send(8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        check("fifo_level_two", 32'(bus.fifo_level), 32'd2);
        p0 = pulses;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        rst_n     = 1'b1;
        hold_busy = 1'b0;
        repeat (30) @(negedge clk);
        check("no_start_after_reset", 32'(pulses - p0), 32'd0);
        check("fifo_level_after_reset", 32'(bus.fifo_level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
